// File: rtl/synth_voice_bank_if.sv
// Event input, sample tick and status/PCM outputs of the square-wave voice bank.
// The master side (stimulus) drives tick and events; the slave side is the bank.
interface synth_voice_bank_if;
  logic        iSampleTick;
  logic        iEventValid;
  logic [7:0]  iEvent;
  logic        oBusy;
  logic [7:0]  oActive;
  logic [15:0] oSample;
  logic        oSampleValid;
  logic        oOverflow;
  logic        oNoVoice;
  logic [1:0]  oDbgState;

  // iEventValid is a one-cycle strobe with no ready: the bank accepts it
  // into a one-entry holding register or, when that is full, drops it and
  // raises the sticky oOverflow flag.
  modport master (
    output iSampleTick, iEventValid, iEvent,
    input  oBusy, oActive, oSample, oSampleValid, oOverflow, oNoVoice, oDbgState
  );

  modport slave (
    input  iSampleTick, iEventValid, iEvent,
    output oBusy, oActive, oSample, oSampleValid, oOverflow, oNoVoice, oDbgState
  );
endinterface

// File: rtl/synth_voice_bank.sv
// Eight-voice square-wave bank: note events allocate/release voices, each sample
// tick advances every voice and registers the signed mix of their levels.
module synth_voice_bank #(
  parameter int VOICES    = 8,
  parameter int AMPLITUDE = 4000
) (
  input  logic               CLK,
  input  logic               Reset,
  synth_voice_bank_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DIV, ALLOC, FIND} state_t;

  localparam logic signed [18:0] AMP = 19'(AMPLITUDE);

  state_t      state_q, state_d;
  logic [6:0]  rem_q, rem_d;
  logic [3:0]  oct_q, oct_d;
  logic [6:0]  p_q, p_d;
  logic        hold_full_q;
  logic [7:0]  hold_ev_q;
  logic        ovf_q, nov_q;
  logic [15:0] sample_q;
  logic        sval_q;

  logic [VOICES-1:0] active_q, level_q;
  logic [6:0]        pitch_q [VOICES];
  logic [11:0]       half_q  [VOICES];
  logic [11:0]       cnt_q   [VOICES];

  logic              alloc_en, find_en, take;
  logic              free_found, match_found;
  logic [2:0]        free_idx, match_idx;
  logic [11:0]       half_raw, half_new;
  logic signed [18:0] mix;

  function automatic logic [11:0] semitone_half(input logic [3:0] s);
    case (s)
      4'd0:    semitone_half = 12'd2936;
      4'd1:    semitone_half = 12'd2771;
      4'd2:    semitone_half = 12'd2615;
      4'd3:    semitone_half = 12'd2468;
      4'd4:    semitone_half = 12'd2330;
      4'd5:    semitone_half = 12'd2199;
      4'd6:    semitone_half = 12'd2076;
      4'd7:    semitone_half = 12'd1959;
      4'd8:    semitone_half = 12'd1849;
      4'd9:    semitone_half = 12'd1745;
      4'd10:   semitone_half = 12'd1648;
      default: semitone_half = 12'd1555;
    endcase
  endfunction

  assign take = (state_q == IDLE) && hold_full_q;

  // Holding register: an incoming strobe while full is lost, including the
  // cycle in which the FSM is draining it.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      hold_full_q <= 1'b0;
      hold_ev_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      if (take) hold_full_q <= 1'b0;
      if (bus.iEventValid) begin
        if (hold_full_q) begin
          ovf_q <= 1'b1;
        end else begin
          hold_full_q <= 1'b1;
          hold_ev_q   <= bus.iEvent;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      oct_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      oct_q   <= oct_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    oct_d    = oct_q;
    p_d      = p_q;
    alloc_en = 1'b0;
    find_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          p_d = hold_ev_q[7:1];
          if (hold_ev_q[0]) begin
            state_d = DIV;
            rem_d   = hold_ev_q[7:1];
            oct_d   = 4'd0;
          end else begin
            state_d = FIND;
          end
        end
      end
      DIV: begin
        if (rem_q >= 7'd12) begin
          rem_d = rem_q - 7'd12;
          oct_d = oct_q + 4'd1;
        end else begin
          state_d = ALLOC;
        end
      end
      ALLOC: begin
        alloc_en = 1'b1;
        state_d  = IDLE;
      end
      FIND: begin
        find_en = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Downward scans leave the lowest matching index as the winner.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = VOICES - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
      if (active_q[i] && (pitch_q[i] == p_q)) begin
        match_found = 1'b1;
        match_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    half_raw = semitone_half(rem_q[3:0]) >> oct_q;
    half_new = (half_raw == 12'd0) ? 12'd1 : half_raw;
  end

  always_comb begin
    mix = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (active_q[i]) mix = mix + (level_q[i] ? AMP : -AMP);
    end
  end

  // Tick advance uses the current voice state; allocation targets an inactive
  // voice, so its fresh settings only count from the following tick.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      active_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < VOICES; i++) begin
        pitch_q[i] <= '0;
        half_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (bus.iSampleTick && active_q[i]) begin
          if (cnt_q[i] == 12'd1) begin
            cnt_q[i]   <= half_q[i];
            level_q[i] <= ~level_q[i];
          end else begin
            cnt_q[i] <= cnt_q[i] - 12'd1;
          end
        end
        if (alloc_en && free_found && (free_idx == 3'(i))) begin
          active_q[i] <= 1'b1;
          pitch_q[i]  <= p_q;
          level_q[i]  <= 1'b1;
          half_q[i]   <= half_new;
          cnt_q[i]    <= half_new;
        end
        if (find_en && match_found && (match_idx == 3'(i))) active_q[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      sample_q <= '0;
      sval_q   <= 1'b0;
      nov_q    <= 1'b0;
    end else begin
      sval_q <= bus.iSampleTick;
      if (bus.iSampleTick) sample_q <= mix[15:0];
      if (alloc_en && !free_found) nov_q <= 1'b1;
    end
  end

  assign bus.oBusy        = (state_q != IDLE);
  assign bus.oActive      = active_q;
  assign bus.oSample      = sample_q;
  assign bus.oSampleValid = sval_q;
  assign bus.oOverflow    = ovf_q;
  assign bus.oNoVoice     = nov_q;
  assign bus.oDbgState    = state_q;

endmodule

// File: tb/tb_synth_voice_bank.sv
// Directed bench for synth_voice_bank: a timeline model of events and voices
// is compared against the DUT every cycle, plus hand-computed literal checks.
module tb_synth_voice_bank;

  localparam int AMP = 4000;

  logic CLK;
  logic Reset;
  synth_voice_bank_if bus_if ();

  synth_voice_bank #(.VOICES(8), .AMPLITUDE(AMP)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus_if)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   tbl [12] = '{2936, 2771, 2615, 2468, 2330, 2199, 2076, 1959, 1849, 1745, 1648, 1555};
  bit   m_active [8];
  bit   m_level  [8];
  int   m_pitch  [8];
  int   m_half   [8];
  int   m_cnt    [8];
  int   m_sample = 0;
  bit   m_valid  = 0;
  bit   m_ovf    = 0;
  bit   m_nov    = 0;
  bit   pend_v   = 0;
  logic [7:0] pend_ev = '0;
  bit   job_v    = 0;
  logic [7:0] job_ev = '0;
  int   job_at   = 0;
  int   cyc      = 0;
  int   mix;
  bit   full_before, idle_before;
  logic [15:0] exp_q [$];

  // A note-on takes the lowest free voice with half = max(1, TABLE[p%12] >> (p/12));
  // a note-off frees the lowest voice holding that pitch.
  task automatic m_apply(input logic [7:0] ev);
    int p;
    bit done;
    p    = int'(ev[7:1]);
    done = 0;
    for (int i = 0; i < 8; i++) begin
      if (!done) begin
        if (ev[0] && !m_active[i]) begin
          m_active[i] = 1;
          m_level[i]  = 1;
          m_pitch[i]  = p;
          m_half[i]   = tbl[p % 12] >> (p / 12);
          if (m_half[i] < 1) m_half[i] = 1;
          m_cnt[i]    = m_half[i];
          done        = 1;
        end else if (!ev[0] && m_active[i] && m_pitch[i] == p) begin
          m_active[i] = 0;
          done        = 1;
        end
      end
    end
    if (ev[0] && !done) m_nov = 1;
  endtask

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) begin
        m_active[i] = 0; m_level[i] = 0; m_pitch[i] = 0; m_half[i] = 0; m_cnt[i] = 0;
      end
      m_sample = 0; m_valid = 0; m_ovf = 0; m_nov = 0;
      pend_v = 0; job_v = 0; cyc = 0;
      exp_q.delete();
    end else begin
      cyc++;
      full_before = pend_v;
      idle_before = !job_v;
      m_valid     = bus_if.iSampleTick;
      if (bus_if.iSampleTick) begin
        mix = 0;
        for (int i = 0; i < 8; i++)
          if (m_active[i]) mix += m_level[i] ? AMP : -AMP;
        m_sample = mix;
        exp_q.push_back(16'(mix));
        for (int i = 0; i < 8; i++) begin
          if (m_active[i]) begin
            if (m_cnt[i] == 1) begin
              m_cnt[i]   = m_half[i];
              m_level[i] = !m_level[i];
            end else begin
              m_cnt[i]--;
            end
          end
        end
      end
      if (job_v && cyc == job_at) begin
        m_apply(job_ev);
        job_v = 0;
      end
      // Note-on needs pitch/12 octave steps plus a final compare and the allocate cycle.
      if (idle_before && pend_v) begin
        job_v  = 1;
        job_ev = pend_ev;
        job_at = cyc + (pend_ev[0] ? int'(pend_ev[7:1]) / 12 + 2 : 1);
        pend_v = 0;
      end
      if (bus_if.iEventValid) begin
        if (full_before) m_ovf = 1;
        else begin
          pend_v  = 1;
          pend_ev = bus_if.iEvent;
        end
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic [7:0]  m_act_vec;
  logic [15:0] exp_s;

  always @(negedge CLK) begin
    for (int i = 0; i < 8; i++) m_act_vec[i] = m_active[i];
    chk("active",   int'(bus_if.oActive), int'(m_act_vec));
    chk("busy",     int'(bus_if.oBusy), int'(job_v));
    chk("overflow", int'(bus_if.oOverflow), int'(m_ovf));
    chk("novoice",  int'(bus_if.oNoVoice), int'(m_nov));
    chk("svalid",   int'(bus_if.oSampleValid), int'(m_valid));
    chk("sample",   int'($signed(bus_if.oSample)), m_sample);
    if (bus_if.oSampleValid) begin
      if (exp_q.size() == 0) begin
        chk("sample_q_empty", 1, 0);
      end else begin
        exp_s = exp_q.pop_front();
        chk("sample_q", int'($signed(bus_if.oSample)), int'($signed(exp_s)));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic tk, input logic v, input logic [7:0] ev);
    bus_if.iSampleTick = tk;
    bus_if.iEventValid = v;
    bus_if.iEvent      = ev;
    @(posedge CLK);
    #2;
    bus_if.iSampleTick = 1'b0;
    bus_if.iEventValid = 1'b0;
    bus_if.iEvent      = 8'h00;
  endtask

  task automatic idle(input int n, input int tick_every);
    for (int k = 0; k < n; k++)
      step((tick_every != 0) && ((k % tick_every) == 0), 1'b0, 8'h00);
  endtask

  task automatic note(input int p, input logic on);
    logic [6:0] p7;
    p7 = 7'(p);
    step(1'b0, 1'b1, {p7, on});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    Reset = 1'b1;
    bus_if.iSampleTick = 1'b0;
    bus_if.iEventValid = 1'b0;
    bus_if.iEvent      = 8'h00;
    repeat (3) @(posedge CLK);
    #2;
    Reset = 1'b0;

    // Silence after reset.
    chk("rst_active", int'(bus_if.oActive), 0);
    chk("rst_sample", int'(bus_if.oSample), 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 8'h00);
      chk("silent_sample", int'($signed(bus_if.oSample)), 0);
      chk("silent_valid", int'(bus_if.oSampleValid), 1);
      step(1'b0, 1'b0, 8'h00);
    end

    // A4: pitch 69 -> oct 5, rem 9, half 54.
    step(1'b0, 1'b1, 8'h8B);
    idle(7, 0);
    chk("a4_not_yet", int'(bus_if.oActive), 0);
    idle(1, 0);
    chk("a4_active", int'(bus_if.oActive), 8'h01);
    chk("a4_half_model", m_half[0], 54);
    for (int k = 0; k < 108; k++) begin
      step(1'b1, 1'b0, 8'h00);
      if (k == 0 || k == 53) chk("a4_high", int'($signed(bus_if.oSample)), 4000);
      if (k == 54 || k == 107) chk("a4_low", int'($signed(bus_if.oSample)), -4000);
      step(1'b0, 1'b0, 8'h00);
    end
    note(69, 1'b0);
    idle(3, 0);
    chk("a4_off", int'(bus_if.oActive), 0);

    // Pitch 127 -> half 1, toggles each tick; pitch 0 -> half 2936.
    note(127, 1'b1);
    idle(14, 0);
    chk("p127_active", int'(bus_if.oActive), 8'h01);
    chk("p127_half_model", m_half[0], 1);
    step(1'b1, 1'b0, 8'h00);
    chk("p127_t0", int'($signed(bus_if.oSample)), 4000);
    step(1'b1, 1'b0, 8'h00);
    chk("p127_t1", int'($signed(bus_if.oSample)), -4000);
    idle(4, 1);
    note(127, 1'b0);
    idle(3, 0);
    note(0, 1'b1);
    idle(4, 0);
    chk("p0_half_model", m_half[0], 2936);
    idle(6, 1);
    chk("p0_sample", int'($signed(bus_if.oSample)), 4000);
    note(0, 1'b0);
    idle(3, 0);

    // Nine note-ons with ticks running: voices fill, the ninth is dropped.
    for (int k = 0; k < 9; k++) begin
      note(60 + k, 1'b1);
      idle(14, 3);
    end
    chk("full_active", int'(bus_if.oActive), 8'hFF);
    chk("full_novoice", int'(bus_if.oNoVoice), 1);
    step(1'b1, 1'b0, 8'h00);
    chk("full_mix", int'($signed(bus_if.oSample)), 32000);
    note(62, 1'b0);
    idle(3, 0);
    chk("off_voice2", int'(bus_if.oActive), 8'hFB);
    for (int k = 0; k < 9; k++) begin
      if (k != 2) begin
        note(60 + k, 1'b0);
        idle(3, 2);
      end
    end
    chk("all_off", int'(bus_if.oActive), 0);

    // Holding register: one held during DIV, the next strobe is lost.
    chk("ovf_clear", int'(bus_if.oOverflow), 0);
    note(100, 1'b1);
    idle(1, 0);
    chk("div_busy", int'(bus_if.oBusy), 1);
    note(50, 1'b1);
    note(40, 1'b1);
    chk("ovf_set", int'(bus_if.oOverflow), 1);
    idle(30, 2);
    chk("ovf_active", int'(bus_if.oActive), 8'h03);
    note(100, 1'b0);
    idle(3, 0);
    note(50, 1'b0);
    idle(3, 0);

    // Reset mid-DIV with three voices sounding.
    note(30, 1'b1); idle(10, 0);
    note(31, 1'b1); idle(10, 0);
    note(32, 1'b1); idle(10, 2);
    chk("three_active", int'(bus_if.oActive), 8'h07);
    note(120, 1'b1);
    idle(3, 0);
    Reset = 1'b1;
    #1;
    chk("mid_rst_active", int'(bus_if.oActive), 0);
    chk("mid_rst_sample", int'(bus_if.oSample), 0);
    chk("mid_rst_busy", int'(bus_if.oBusy), 0);
    chk("mid_rst_ovf", int'(bus_if.oOverflow), 0);
    chk("mid_rst_nov", int'(bus_if.oNoVoice), 0);
    @(posedge CLK);
    #2;
    Reset = 1'b0;
    idle(2, 0);
    note(45, 1'b1);
    idle(7, 0);
    chk("post_rst_voice0", int'(bus_if.oActive), 8'h01);
    idle(10, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/synth_voice_bank.md
Name: synth_voice_bank

Overview:
- Downstream consumer of the syscall synthesizer control's note-event byte.
- Turns note-on/off events {pitch[6:0], on} into up to 8 simultaneous square-wave voices.
- Mixes the active voices into one signed 16-bit PCM sample per sample tick, for the audio DAC serializer.
- Runs entirely on CLK; the sample rate arrives as a one-cycle iSampleTick strobe synchronous to CLK (48 kHz nominal).

Parameters:
- VOICES, 8, number of voices. Fixed at 8; the allocation logic assumes 8.
- AMPLITUDE, 4000, per-voice square amplitude. 8*AMPLITUDE must be ≤ 32767.

Ports:
- CLK, in, 1, system clock.
- Reset, in, 1, asynchronous active-high reset.
- iSampleTick, in, 1, one-CLK pulse per audio sample.
- iEventValid, in, 1, one-CLK strobe qualifying iEvent.
- iEvent, in, 8, [7:1] MIDI pitch 0..127, [0] 1 = note-on, 0 = note-off.
- oBusy, out, 1, high whenever the FSM is not IDLE.
- oActive, out, 8, per-voice active flags.
- oSample, out, 16, signed mixed sample.
- oSampleValid, out, 1, one-CLK pulse when oSample updates.
- oOverflow, out, 1, sticky: an event was lost.
- oNoVoice, out, 1, sticky: a note-on was dropped because all voices were busy.

Behaviour:
- Reset (async, active-high) clears all state and outputs: oSample=0, oSampleValid=0, oActive=0, oBusy=0, oOverflow=0, oNoVoice=0, FSM=IDLE. Sticky flags clear only on Reset.
- Event holding register (1 entry):
  - iEventValid while the register is empty: latch iEvent.
  - iEventValid while the register is full: discard the new event and set oOverflow.
  - The register empties in the cycle the FSM leaves IDLE with it.
- FSM states: IDLE, DIV, ALLOC, FIND.
  - IDLE: if the holding register is full, go to DIV on note-on (rem=pitch, oct=0) or to FIND on note-off.
  - DIV: one step per cycle. If rem ≥ 12 then rem -= 12, oct += 1; else go to ALLOC. rem is 7 bits, oct 4 bits (0..10).
  - ALLOC: take the lowest-index inactive voice and set active=1, pitch=p, level=1, half=max(1, TABLE[rem] >> oct), cnt=half. If no voice is free, set oNoVoice and change nothing. Return to IDLE.
  - FIND: clear active on the lowest-index active voice whose stored pitch equals p. No match: ignore. Return to IDLE.
  - Note-on of a pitch already sounding allocates an additional voice. Note-off releases only one voice.
- TABLE (half-period in samples at 48 kHz, octave 0; semitone 0..11): 2936, 2771, 2615, 2468, 2330, 2199, 2076, 1959, 1849, 1745, 1648, 1555. 12-bit counters.
- Note-on latency: valid → latched (+1) → IDLE→DIV (+1) → oct+1 DIV cycles → ALLOC (+1). Voice active by cycle 4+oct after iEventValid. Note-off: active cleared by cycle 3.
- On iSampleTick, for each active voice:
  - cnt==1: reload cnt=half and toggle level.
  - otherwise: cnt -= 1.
- Sample output:
  - On the tick, the mix sums the pre-update levels: +AMPLITUDE for level=1, -AMPLITUDE for level=0, over active voices only. Inactive voices contribute 0.
  - Accumulate in 19 bits signed and register to oSample; oSampleValid pulses in the CLK after the tick (latency 1).
- Simultaneous events:
  - ALLOC/FIND in the same cycle as a tick: the tick uses pre-change voice state. A new voice contributes from the next tick.
  - Tick while busy: sample generation is never stalled.
  - iEventValid in the same cycle the holding register empties: the register is still full that cycle → overflow.
- Reset mid-note or mid-DIV: the machine returns to IDLE, all voices silent, the pending event is lost.

Test Plan:
- Reset then 3 ticks with no events → oSample=0, 3 oSampleValid pulses, oActive=0.
- Note-on pitch 69 (iEvent=8'h8B) → oct=5, rem=9, half=1745>>5=54; oActive=8'h01 at cycle 9; oSample=+4000 for 54 ticks, then -4000 for 54 ticks.
- Note-on pitch 127 → half=1959>>10=1, output toggles every tick; pitch 0 → half=2936.
- 9 note-ons, spaced ≥15 cycles apart → oActive=8'hFF, 9th sets oNoVoice. Then note-off of voice 2's pitch → oActive=8'hFB.
- Two iEventValid strobes on consecutive cycles during DIV → second held, a third while full sets oOverflow.
- Reset asserted mid-DIV with 3 voices active → outputs zero immediately; after release a new note-on allocates voice 0.
